dm_responder: RTL

- Memory-side responder for the CPU data-memory port. It accepts load/store requests (enable, write-enable, byte address, write data) and services them against an internal word array after a programmable access latency.
- It returns read data with a one-cycle ready pulse.
- It flags misaligned and out-of-range accesses, so a multi-cycle or stalled CPU variant can sit on a realistic memory model.

---
 rtl/dm_responder.sv | 102 ++++++++++
 1 files changed

// File: rtl/dm_responder.sv
// dm_responder: latency-programmable data-memory responder with misaligned/out-of-range
// access detection and a sticky first-error address capture.
`default_nettype none

module dm_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic        wena,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        ready,
  output logic        busy,
  output logic        err,
  output logic [31:0] err_addr,
  input  logic        err_clr
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic          req_we;
  logic [31:0]   req_addr;
  logic [31:0]   req_data;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] idx;
  logic          bad;
  logic          done;

  assign idx   = req_addr[AW+1:2];
  // Anything above the top word-index bit, or a non-word-aligned byte offset, is an error.
  assign bad   = (req_addr[1:0] != 2'b00) || ((req_addr >> (AW + 2)) != 32'd0);
  assign done  = (state == WAIT) && (cnt == 4'd0);
  assign busy  = (state != IDLE);
  assign ready = (state == RESP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      req_we   <= 1'b0;
      req_addr <= 32'd0;
      req_data <= 32'd0;
      data_out <= 32'd0;
      err      <= 1'b0;
      err_addr <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (ena) begin
            req_we   <= wena;
            req_addr <= addr;
            req_data <= data_in;
            cnt      <= 4'(LATENCY - 1);
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= RESP;
            if (!req_we) begin
              data_out <= bad ? 32'd0 : mem[idx];
            end
          end
        end
        default: state <= IDLE;
      endcase

      // A completing error takes priority over a simultaneous clear.
      if (done && bad) begin
        err <= 1'b1;
        if (!err || err_clr) begin
          err_addr <= req_addr;
        end
      end else if (err_clr) begin
        err      <= 1'b0;
        err_addr <= 32'd0;
      end
    end
  end

  // Write only on completion; reset forces IDLE so an interrupted store never lands.
  always_ff @(posedge clk) begin
    if (done && req_we && !bad) begin
      mem[idx] <= req_data;
    end
  end

endmodule

`default_nettype wire
